gate_truth_checker: RTL and testbench

- Self-test stage wrapped around the two-input gate library (and, or, not, nand, nor, xor, xnor).
- Upstream side: on a start pulse, drives all four (a,b) input combinations onto the shared gate inputs.
- Downstream side: after a programmable settle time, samples the 7 gate outputs and compares them with the expected truth table.
- Reports a sticky per-gate error mask plus a pass/done result; used as a bring-up and regression harness for the gate library.

---
 rtl/gate_check_pkg.sv | 38 +++
 rtl/gate_expected_rom.sv | 12 +
 rtl/gate_truth_checker.sv | 94 +++++++++
 tb/tb_gate_truth_checker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared types, constants and truth table for the gate truth checker
package gate_check_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam int GATE_CNT = 7;
   localparam int SETTLE_W = 4;

   // Bit positions of each gate within the gate_out bus
   localparam int GATE_AND  = 0;
   localparam int GATE_OR   = 1;
   localparam int GATE_NOT  = 2;
   localparam int GATE_NAND = 3;
   localparam int GATE_NOR  = 4;
   localparam int GATE_XOR  = 5;
   localparam int GATE_XNOR = 6;

   // Golden response of a correct gate library to stimulus (a, b); the not gate sees a only
   function automatic logic [GATE_CNT-1:0] expected_vec(input logic a, input logic b);
      logic [GATE_CNT-1:0] v;
      v            = '0;
      v[GATE_AND]  = a & b;
      v[GATE_OR]   = a | b;
      v[GATE_NOT]  = ~a;
      v[GATE_NAND] = ~(a & b);
      v[GATE_NOR]  = ~(a | b);
      v[GATE_XOR]  = a ^ b;
      v[GATE_XNOR] = ~(a ^ b);
      return v;
   endfunction

endpackage

// File: rtl/gate_expected_rom.sv
// rtl/gate_expected_rom.sv - combinational expected-vector lookup for one stimulus pattern
module gate_expected_rom
   import gate_check_pkg::*;
(
   input  logic [1:0]          pattern,
   output logic [GATE_CNT-1:0] expected
);

   // pattern[1] is the a input, pattern[0] is the b input
   assign expected = expected_vec(pattern[1], pattern[0]);

endmodule

// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - drives all four input patterns into the gate library and checks its outputs
module gate_truth_checker
   import gate_check_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                stim_a,
   output logic                stim_b,
   input  logic [GATE_CNT-1:0] gate_out,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [GATE_CNT-1:0] err_mask
);

   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

   state_t                state;
   logic [1:0]            pattern;
   logic [SETTLE_W-1:0]   settle_cnt;
   logic [GATE_CNT-1:0]   expected;
   logic [GATE_CNT-1:0]   err_next;

   gate_expected_rom u_rom (
      .pattern  (pattern),
      .expected (expected)
   );

   // Accumulated mismatch including the pattern currently being sampled
   assign err_next = err_mask | (gate_out ^ expected);

   // Run sequencer: stimulus, settle timing, sampling and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         stim_a     <= 1'b0;
         stim_b     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_mask   <= '0;
         pattern    <= 2'd0;
         settle_cnt <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state    <= DRIVE;
                  pattern  <= 2'd0;
                  err_mask <= '0;
                  pass     <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            DRIVE: begin
               stim_a     <= pattern[1];
               stim_b     <= pattern[0];
               settle_cnt <= SETTLE_LOAD;
               state      <= (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
            end
            SETTLE: begin
               settle_cnt <= settle_cnt - SETTLE_W'(1);
               if (settle_cnt == SETTLE_W'(1)) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               err_mask <= err_next;
               if (pattern == 2'd3) begin
                  state <= DONE;
                  pass  <= (err_next == '0);
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  pattern <= pattern + 2'd1;
                  state   <= DRIVE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb/tb_gate_truth_checker.sv - scoreboard bench for gate_truth_checker at settle times 1, 0 and 3
module tb_gate_truth_checker;

   localparam int N = 3;

   typedef struct {
      int         accept;
      int         done_edge;
      logic [6:0] err;
      logic       pass;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   start;
   logic [N-1:0]   stim_a;
   logic [N-1:0]   stim_b;
   logic [N-1:0]   busy;
   logic [N-1:0]   done;
   logic [N-1:0]   pass;
   logic [6:0]     gate_out [N];
   logic [6:0]     err_mask [N];
   logic [6:0]     f_zero   [N];
   logic [6:0]     f_inv    [N];
   logic [6:0]     nz       [N];
   logic [6:0]     ni       [N];
   logic [1:0]     rom_pat;
   logic [6:0]     rom_exp;

   exp_t sbq [N][$];
   int   free_at [N];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int settle_of(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
   endfunction

   // Behaviour of a healthy gate library, bit order and, or, not(a), nand, nor, xor, xnor
   function automatic logic [6:0] good(input logic a, input logic b);
      return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
   endfunction

   // Which gates a faulty library gets wrong over the four input combinations
   function automatic logic [6:0] model_err(input logic [6:0] fz, input logic [6:0] fi);
      logic [6:0] e;
      logic [1:0] pv;
      logic [6:0] g;
      e = '0;
      for (int p = 0; p < 4; p++) begin
         pv = 2'(p);
         g  = good(pv[1], pv[0]);
         e  = e | (((g & ~fz) ^ fi) ^ g);
      end
      return e;
   endfunction

   task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d @edge %0d: got 0x%0h, expected 0x%0h", name, inst, cyc, act, exp);
      end
   endtask

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int S_G = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
      gate_truth_checker #(.SETTLE_CYCLES(S_G)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .start    (start[g]),
         .stim_a   (stim_a[g]),
         .stim_b   (stim_b[g]),
         .gate_out (gate_out[g]),
         .busy     (busy[g]),
         .done     (done[g]),
         .pass     (pass[g]),
         .err_mask (err_mask[g])
      );
      assign gate_out[g] = (good(stim_a[g], stim_b[g]) & ~f_zero[g]) ^ f_inv[g];
   end

   gate_expected_rom u_rom (
      .pattern  (rom_pat),
      .expected (rom_exp)
   );

   // One clock of stimulus; a start that the checker will accept creates a scoreboard entry
   task automatic tick(input logic [N-1:0] st);
      int   e;
      exp_t x;
      e     = cyc + 1;
      start = st;
      for (int i = 0; i < N; i++) begin
         if (st[i] && (e >= free_at[i])) begin
            f_zero[i]   = nz[i];
            f_inv[i]    = ni[i];
            x.accept    = e;
            x.done_edge = e + 4 * (settle_of(i) + 2);
            x.err       = model_err(nz[i], ni[i]);
            x.pass      = (x.err == 7'h00);
            sbq[i].push_back(x);
            free_at[i]  = x.done_edge + 2;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) tick('0);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      start = '0;
      for (int i = 0; i < N; i++) sbq[i].delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         free_at[i] = cyc + 1;
         chk("rst_stim", i, {30'd0, stim_a[i], stim_b[i]}, 32'd0);
         chk("rst_busy", i, {31'd0, busy[i]}, 32'd0);
         chk("rst_done", i, {31'd0, done[i]}, 32'd0);
         chk("rst_pass", i, {31'd0, pass[i]}, 32'd0);
         chk("rst_err", i, {25'd0, err_mask[i]}, 32'd0);
      end
   endtask

   task automatic set_faults(input logic [6:0] z0, input logic [6:0] i0, input logic [6:0] z1,
                             input logic [6:0] i1, input logic [6:0] z2, input logic [6:0] i2);
      nz[0] = z0; ni[0] = i0;
      nz[1] = z1; ni[1] = i1;
      nz[2] = z2; ni[2] = i2;
   endtask

   task automatic rand_faults();
      for (int i = 0; i < N; i++) begin
         nz[i] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
         ni[i] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
      end
   endtask

   // Monitor: per-run timing and stimulus checks, result comparison on every done pulse
   initial begin
      exp_t h;
      int   s;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            s = settle_of(i);
            if (sbq[i].size() > 0) begin
               h = sbq[i][0];
               if (cyc == h.accept) begin
                  chk("accept_busy", i, {31'd0, busy[i]}, 32'd1);
                  chk("accept_pass", i, {31'd0, pass[i]}, 32'd0);
                  chk("accept_err", i, {25'd0, err_mask[i]}, 32'd0);
               end
               for (int k = 0; k < 4; k++) begin
                  if (cyc == h.accept + 1 + k * (s + 2)) begin
                     chk("stim_seq", i, {30'd0, stim_a[i], stim_b[i]}, 32'(k));
                     chk("run_busy", i, {31'd0, busy[i]}, 32'd1);
                  end
               end
               if (done[i]) begin
                  void'(sbq[i].pop_front());
                  chk("done_edge", i, 32'(cyc), 32'(h.done_edge));
                  chk("err_mask", i, {25'd0, err_mask[i]}, {25'd0, h.err});
                  chk("pass", i, {31'd0, pass[i]}, {31'd0, h.pass});
                  chk("done_busy", i, {31'd0, busy[i]}, 32'd0);
                  chk("done_stim", i, {30'd0, stim_a[i], stim_b[i]}, 32'd3);
               end else if (cyc >= h.done_edge) begin
                  void'(sbq[i].pop_front());
                  chk("missing_done", i, {31'd0, done[i]}, 32'd1);
               end
            end else if (!rst) begin
               chk("idle_done", i, {31'd0, done[i]}, 32'd0);
               chk("idle_busy", i, {31'd0, busy[i]}, 32'd0);
            end
         end
      end
   end

   // Stimulus sequence
   initial begin
      int a_edge;
      start = '0;
      set_faults(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < N; i++) begin
         f_zero[i] = 7'h00;
         f_inv[i]  = 7'h00;
      end
      rom_pat = 2'd0;
      do_reset();

      for (int p = 0; p < 4; p++) begin
         rom_pat = 2'(p);
         #1;
         chk("rom", p, {25'd0, rom_exp}, {25'd0, good(rom_pat[1], rom_pat[0])});
      end

      // Healthy library on all settle settings
      tick(3'b111);
      idle(30);

      // Stuck xor, then xor plus inverted nand/not, with start spam while busy
      set_faults(7'h20, 7'h00, 7'h20, 7'h0C, 7'h00, 7'h00);
      tick(3'b111);
      repeat (25) tick(3'($urandom_range(0, 7)));
      idle(30);

      // Faulty run straight after a passing run
      set_faults(0, 0, 0, 0, 0, 0);
      tick(3'b100);
      idle(25);
      set_faults(0, 0, 0, 0, 7'h00, 7'h01);
      tick(3'b100);
      idle(25);

      // Start held high: back-to-back runs
      repeat (70) begin
         if ($urandom_range(0, 9) == 0) rand_faults();
         tick(3'b111);
      end
      idle(30);

      // Reset during the settle phase of pattern 2, then a clean run
      set_faults(0, 0, 0, 0, 0, 0);
      tick(3'b001);
      a_edge = cyc;
      while (cyc < a_edge + 7) tick('0);
      do_reset();
      idle(3);
      tick(3'b111);
      idle(30);

      // Random faults and start traffic
      for (int r = 0; r < 40; r++) begin
         rand_faults();
         tick(3'($urandom_range(0, 7)));
         repeat ($urandom_range(0, 12)) tick(3'($urandom_range(0, 7)));
      end
      idle(40);

      for (int i = 0; i < N; i++) chk("leftover_runs", i, 32'(sbq[i].size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: bench did not complete within time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
